irq_priority_encoder: RTL and testbench
=======================================

# irq_priority_encoder

Sequential 8-to-3 priority encoder, the encode-side counterpart of the team's 3-to-8 enable decoder. It captures rising edges on N request lines into a sticky pending register and offers the highest-index unmasked pending request as a binary code. The code is held on a valid/ready handshake and the pending bit is cleared on acceptance. It sits between raw event/interrupt sources and a consumer that wants one indexed event at a time. Its code output can drive the decoder's select inputs directly.

## Interface
- N, 8: number of request lines.
- W, 3: code width. Must equal clog2(N); elaboration error otherwise.

- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  capture enable. When 0, no new edges are captured. The handshake continues regardless.
- req  input  N  level request lines. Only a 0→1 transition is an event.
- mask  input  N  1 = bit not eligible for offer. The pending bit still latches.
- ready  input  1  consumer accepts the offered code when valid & ready.
- code  output  W  index of the offered request. Registered.
- valid  output  1  code is valid. Registered.
- pending  output  N  sticky pending register, visible to the consumer.

## Operation
- Edge detection:
  - req_q is the registered copy of req.
  - rise = req & ~req_q.
  - During reset, req_q <= req, so lines already high at reset release are not events.
- Pending update: pending <= (pending & ~clr) | (rise & {N{en}}).
  - clr is onehot(code) when accept = valid & ready, else 0.
  - Set wins: a rise on a bit in the same cycle it is cleared leaves that bit set.
- Eligibility: elig = pending & ~mask.
- Priority: the highest set index of elig wins (bit N-1 highest).
- FSM, two states:
  - IDLE (valid=0):
    - If elig != 0: code <= highest index of elig, valid <= 1, go to OFFER.
    - Otherwise stay in IDLE. code holds its last value.
  - OFFER (valid=1):
    - code and valid are frozen until accept.
    - Later higher-priority arrivals, mask changes on the offered bit, and en changes do not alter or withdraw the offer.
    - On accept: pending[code] cleared (subject to set-wins), valid <= 0, go to IDLE.
- Throughput: at most one grant per 2 cycles. A mandatory one-cycle IDLE gap follows every accept.
- en=0 only suppresses capture. Already-pending bits are still offered and cleared.
- Reset values:
  - code = 0, valid = 0, pending = 0.
  - State = IDLE, req_q = req.
  - A reset asserted mid-offer drops valid on the next edge and discards all pending bits.

## Timing
- Req sampled high (prior sample low) at edge t:
  - pending bit visible after edge t.
  - valid=1 with code after edge t+1. Latency is 2 edges.
- Accept at edge u:
  - valid=0 and pending bit cleared after edge u.
  - The next offer, if elig != 0, is visible after edge u+1.
- valid & ready held continuously: a valid pulse of 1 cycle every 2 cycles.
- ready is a don't-care while valid=0. ready may be high before valid rises; accept then occurs on the first valid cycle.
- No combinational path from any input to any output.

## Test plan
- Reset filter: hold req=8'hFF through rst, release. Required: pending=0 and valid=0 for 10 cycles. A subsequent 0→1 on req[0] yields code=0.
- Single event: req[5] pulses high 1 cycle, ready=1. Required: pending=8'h20 after edge t, valid=1 with code=5 after edge t+1, pending=8'h00 and valid=0 after the next edge.
- Simultaneous events: rises on bits 1, 4, 6 in one cycle, ready=1. Required: codes 6, 4, 1 on successive valid cycles spaced 2 cycles apart, then pending=0.
- Masking and backpressure:
  - Rises on bits 7 and 2 with mask=8'h80. Required: code=2 offered.
  - Hold ready=0 for 5 cycles and raise req[3]. Required: code stays 2 and valid stays 1.
  - Set mask=0, then ready=1. Required: 7 then 3 offered.
- Set-wins and en:
  - req[3] rises on the same edge code=3 is accepted. Required: pending[3] stays 1 and code=3 is re-offered.
  - With en=0, a pulse on req[6]. Required: pending[6] stays 0.
- Reset mid-offer: rst asserted while valid=1 with pending=8'h14. Required: after that edge valid=0, code=0, pending=0.

Source files
------------

// File: rtl/irq_priority_encoder_if.sv
// Offer channel of the IRQ priority encoder: registered code/valid,
// consumer ready, and the sticky pending vector.
interface irq_priority_encoder_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic [W-1:0] code;
    logic         valid;
    logic         ready;
    logic [N-1:0] pending;

    modport master (
        output code,
        output valid,
        output pending,
        input  ready
    );

    modport slave (
        input  code,
        input  valid,
        input  pending,
        output ready
    );
endinterface

// File: rtl/irq_priority_encoder.sv
// Sticky rising-edge capture of request lines; offers the highest unmasked
// pending index on a valid/ready channel and clears it on acceptance.
module irq_priority_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    irq_priority_encoder_if.master bus
);
    if (W != $clog2(N)) begin : g_bad_width
        $error("irq_priority_encoder: W must equal clog2(N)");
    end

    typedef enum logic {IDLE, OFFER} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] code_q, code_d;
    logic         valid_q, valid_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] req_q;

    logic [N-1:0] rise;
    logic [N-1:0] elig;
    logic [N-1:0] clr;
    logic [W-1:0] top_idx;
    logic         accept;

    always_comb begin
        rise   = req & ~req_q;
        elig   = pending_q & ~mask;
        accept = valid_q & bus.ready;
        clr    = accept ? (N'(1) << code_q) : '0;
        // set wins over clear on the same bit
        pending_d = (pending_q & ~clr) | (rise & {N{en}});
    end

    // ascending scan: the last hit is the highest index
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) top_idx = W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    code_d  = top_idx;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            req_q     <= req;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            req_q     <= req;
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_irq_priority_encoder.sv
// Randomized and directed bench for irq_priority_encoder with an
// array-based reference model feeding an offer scoreboard.
module tb_irq_priority_encoder;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] mask;

    irq_priority_encoder_if #(.N(N), .W(W)) bus ();

    irq_priority_encoder #(.N(N), .W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .req  (req),
        .mask (mask),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int cyc;
    } offer_t;

    offer_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    bit m_pend[N];
    bit m_prev[N];
    int m_offer = -1;
    int m_code  = 0;
    int cyc     = 0;
    bit mon_en  = 0;
    bit prev_v  = 0;

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic int model_pend_vec();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_pend[i]) v += (1 << i);
        return v;
    endfunction

    // Reference: pending as a bit array, current offer as an index (-1 none)
    always @(posedge clk) begin
        bit old[N];
        int old_offer;
        bit acc;
        int best;
        cyc++;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0;
                m_prev[i] = req[i];
            end
            m_offer = -1;
            m_code  = 0;
        end else begin
            old       = m_pend;
            old_offer = m_offer;
            acc       = (old_offer >= 0) && bus.ready;
            if (old_offer < 0) begin
                best = -1;
                for (int i = 0; i < N; i++)
                    if (old[i] && !mask[i]) best = i;
                if (best >= 0) begin
                    m_offer = best;
                    m_code  = best;
                    exp_q.push_back('{best, cyc});
                end
            end else if (acc) begin
                m_offer = -1;
            end
            for (int i = 0; i < N; i++) begin
                bit rose;
                rose = req[i] && !m_prev[i];
                m_pend[i] = (old[i] && !(acc && i == old_offer)) ||
                            (rose && en);
                m_prev[i] = req[i];
            end
        end
    end

    // Monitor: per-cycle state compare plus scoreboard pop on each new offer
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", int'(bus.valid), int'(m_offer >= 0));
            chk("pending", int'(bus.pending), model_pend_vec());
            chk("code", int'(bus.code), m_code);
            if (bus.valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_offer", int'(bus.code), -1);
                end else begin
                    offer_t e;
                    e = exp_q.pop_front();
                    chk("offer_code", int'(bus.code), e.code);
                    chk("offer_cycle", cyc, e.cyc);
                end
            end
            prev_v = bus.valid;
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        req       = 8'hFF;
        mask      = 8'h00;
        bus.ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mon_en = 1;
        chk("reset_valid", int'(bus.valid), 0);
        chk("reset_code", int'(bus.code), 0);
        chk("reset_pending", int'(bus.pending), 0);
        step(2);
        rst = 1'b0;

        // reset filter
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("filter_pending", int'(bus.pending), 0);
            chk("filter_valid", int'(bus.valid), 0);
        end
        req = 8'h00;
        bus.ready = 1'b1;
        step(1);
        req = 8'h01;
        step(2);
        chk("bit0_valid", int'(bus.valid), 1);
        chk("bit0_code", int'(bus.code), 0);
        req = 8'h00;
        step(3);

        // single event
        req = 8'h20;
        step(1);
        chk("single_pending", int'(bus.pending), 'h20);
        chk("single_valid_early", int'(bus.valid), 0);
        req = 8'h00;
        step(1);
        chk("single_valid", int'(bus.valid), 1);
        chk("single_code", int'(bus.code), 5);
        step(1);
        chk("single_cleared", int'(bus.pending), 0);
        chk("single_valid_low", int'(bus.valid), 0);
        step(2);

        // simultaneous events
        req = 8'h52;
        step(1);
        req = 8'h00;
        step(8);
        chk("simul_drained", int'(bus.pending), 0);

        // masking and backpressure
        bus.ready = 1'b0;
        mask = 8'h80;
        req  = 8'h84;
        step(1);
        req = 8'h00;
        step(1);
        chk("mask_valid", int'(bus.valid), 1);
        chk("mask_code", int'(bus.code), 2);
        req = 8'h08;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_code", int'(bus.code), 2);
            chk("bp_valid", int'(bus.valid), 1);
        end
        mask = 8'h00;
        bus.ready = 1'b1;
        step(8);
        req = 8'h00;
        chk("mask_drained", int'(bus.pending), 0);
        step(2);

        // set wins
        bus.ready = 1'b0;
        req = 8'h08;
        step(1);
        req = 8'h00;
        step(1);
        chk("sw_code", int'(bus.code), 3);
        bus.ready = 1'b1;
        req = 8'h08;
        step(1);
        chk("sw_pending3", int'(bus.pending[3]), 1);
        chk("sw_valid_gap", int'(bus.valid), 0);
        step(1);
        chk("sw_reoffer_valid", int'(bus.valid), 1);
        chk("sw_reoffer_code", int'(bus.code), 3);
        req = 8'h00;
        step(3);

        // capture disabled
        en  = 1'b0;
        req = 8'h40;
        step(1);
        chk("en0_pending6", int'(bus.pending[6]), 0);
        req = 8'h00;
        step(1);
        chk("en0_valid", int'(bus.valid), 0);
        en = 1'b1;
        step(1);

        // reset mid-offer
        bus.ready = 1'b0;
        req = 8'h14;
        step(1);
        req = 8'h00;
        step(1);
        chk("mid_valid", int'(bus.valid), 1);
        chk("mid_pending", int'(bus.pending), 'h14);
        rst = 1'b1;
        step(1);
        chk("mid_rst_valid", int'(bus.valid), 0);
        chk("mid_rst_code", int'(bus.code), 0);
        chk("mid_rst_pending", int'(bus.pending), 0);
        rst = 1'b0;
        step(1);

        // random
        for (int i = 0; i < 600; i++) begin
            req       = N'($urandom);
            mask      = ($urandom_range(3) == 0) ? N'($urandom) : '0;
            bus.ready = ($urandom_range(2) != 0);
            en        = ($urandom_range(7) != 0);
            rst       = ($urandom_range(63) == 0);
            step(1);
        end

        // drain
        rst = 1'b0;
        en = 1'b1;
        req = 8'h00;
        mask = 8'h00;
        bus.ready = 1'b1;
        step(24);
        chk("final_pending", int'(bus.pending), 0);
        chk("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
